// File: rtl/fir_lpf_serial.sv
// rtl/fir_lpf_serial.sv - 16-tap symmetric low-pass FIR, one shared multiplier, one MAC pass per s_clk edge.
// Define FIR_LPF_SAT_EN to clamp the output to DW bits and raise the sticky sat flag; otherwise it wraps.
module fir_lpf_serial #(
  parameter int TAPS = 16,
  parameter int DW   = 12,
  parameter int CW   = 16,
  parameter int AW   = DW + CW + 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_clk,
  input  logic signed [DW-1:0] din,
  output logic signed [DW-1:0] dout,
  output logic                 dout_valid,
  output logic                 busy,
  output logic                 ovr,
  output logic                 sat
);

  localparam int KW = $clog2(TAPS);
  localparam logic signed [AW-1:0] HALF = AW'(2 ** (CW - 2));

  typedef enum logic [1:0] {IDLE, MAC, ROUND} state_t;

  state_t                state_q, state_d;
  logic                  s_q;
  logic                  s_edge;
  logic signed [DW-1:0]  buf_q [TAPS];
  logic [KW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [KW-1:0]         k_q, k_d;
  logic [KW-1:0]         rd_idx;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic signed [AW-1:0]  rnd;
  logic signed [CW-1:0]  h_k;
  logic signed [DW-1:0]  dout_q, dout_d;
  logic                  valid_q, valid_d;
  logic                  ovr_q, ovr_d;

  // Only half the table is stored; the upper taps mirror the lower ones.
  function automatic logic signed [CW-1:0] coef(input logic [KW-1:0] k);
    logic [KW-1:0] m;
    m = (k < KW'(TAPS / 2)) ? k : KW'(TAPS - 1) - k;
    case (int'(m))
      0:       coef = CW'(-256);
      1:       coef = CW'(-512);
      2:       coef = CW'(0);
      3:       coef = CW'(1024);
      4:       coef = CW'(2304);
      5:       coef = CW'(3584);
      6:       coef = CW'(4608);
      7:       coef = CW'(5632);
      default: coef = '0;
    endcase
  endfunction

  assign s_edge = s_clk & ~s_q;
  assign h_k    = coef(k_q);
  assign rd_idx = (k_q > wr_ptr_q) ? wr_ptr_q + KW'(TAPS) - k_q : wr_ptr_q - k_q;
  assign rnd    = acc_q + HALF;

`ifdef FIR_LPF_SAT_EN
  localparam logic signed [AW-1:0] MAXV = AW'(2 ** (DW - 1) - 1);
  localparam logic signed [AW-1:0] MINV = AW'(-(2 ** (DW - 1)));
  logic signed [AW-1:0] r_full;
  logic                 sat_q, sat_d;
  assign r_full = rnd >>> (CW - 1);
  assign sat    = sat_q;
`else
  logic signed [DW-1:0] r_wrap;
  assign r_wrap = DW'(rnd >>> (CW - 1));
  assign sat    = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    k_d      = k_q;
    wr_ptr_d = wr_ptr_q;
    dout_d   = dout_q;
    valid_d  = 1'b0;
    ovr_d    = ovr_q | (s_edge & (state_q != IDLE));
`ifdef FIR_LPF_SAT_EN
    sat_d    = sat_q;
`endif
    case (state_q)
      IDLE: begin
        if (s_edge) begin
          acc_d   = '0;
          k_d     = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + AW'(buf_q[rd_idx]) * AW'(h_k);
        if (k_q == KW'(TAPS - 1)) begin
          state_d  = ROUND;
          wr_ptr_d = (wr_ptr_q == KW'(TAPS - 1)) ? '0 : wr_ptr_q + KW'(1);
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      ROUND: begin
`ifdef FIR_LPF_SAT_EN
        if (r_full > MAXV) begin
          dout_d = DW'(MAXV);
          sat_d  = 1'b1;
        end else if (r_full < MINV) begin
          dout_d = DW'(MINV);
          sat_d  = 1'b1;
        end else begin
          dout_d = DW'(r_full);
        end
`else
        dout_d = r_wrap;
`endif
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      s_q      <= 1'b0;
      acc_q    <= '0;
      k_q      <= '0;
      wr_ptr_q <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
`ifdef FIR_LPF_SAT_EN
      sat_q    <= 1'b0;
`endif
      for (int i = 0; i < TAPS; i++) buf_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_clk;
      acc_q    <= acc_d;
      k_q      <= k_d;
      wr_ptr_q <= wr_ptr_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
`ifdef FIR_LPF_SAT_EN
      sat_q    <= sat_d;
`endif
      if (state_q == IDLE && s_edge) buf_q[wr_ptr_q] <= din;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign busy       = (state_q != IDLE);
  assign ovr        = ovr_q;

endmodule

// File: tb/tb_fir_lpf_serial.sv
// tb/tb_fir_lpf_serial.sv - directed bench for fir_lpf_serial; honours FIR_LPF_SAT_EN when defined.
module tb_fir_lpf_serial;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               s_clk = 1'b0;
  logic signed [11:0] din = '0;
  logic signed [11:0] dout;
  logic               dout_valid, busy, ovr, sat;

  int checks = 0;
  int errors = 0;

  int H [16] = '{-256, -512, 0, 1024, 2304, 3584, 4608, 5632,
                 5632, 4608, 3584, 2304, 1024, 0, -512, -256};
  int IMP [16] = '{-16, -32, 0, 64, 144, 224, 288, 352,
                   352, 288, 224, 144, 64, 0, -32, -16};
  int hist [16];

`ifdef FIR_LPF_SAT_EN
  localparam int OVERSHOOT = 2047;
  localparam int SAT_END   = 1;
`else
  localparam int OVERSHOOT = -1953;
  localparam int SAT_END   = 0;
`endif

  fir_lpf_serial dut (
    .clk(clk), .rst(rst), .s_clk(s_clk), .din(din), .dout(dout),
    .dout_valid(dout_valid), .busy(busy), .ovr(ovr), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void push(input int x);
    for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = x;
  endfunction

  function automatic void clear_hist();
    for (int i = 0; i < 16; i++) hist[i] = 0;
  endfunction

  function automatic int model();
    longint acc = 0;
    longint r;
    for (int k = 0; k < 16; k++) acc += longint'(hist[k]) * longint'(H[k]);
    r = (acc + 16384) >>> 15;
`ifdef FIR_LPF_SAT_EN
    if (r > 2047) r = 2047;
    if (r < -2048) r = -2048;
`else
    r = r & 4095;
    if (r >= 2048) r = r - 4096;
`endif
    return int'(r);
  endfunction

  task automatic sample(input int x, output int val);
    int lat;
    logic pw;
    lat = -1;
    val = 0;
    pw  = 1'bx;
    @(posedge clk);
    #1;
    s_clk = 1'b1;
    din   = 12'(x);
    push(x);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 1) begin
        s_clk = 1'b0;
        din   = 12'sh5A5;
      end
      if (lat >= 0 && i == lat + 1) begin
        pw = dout_valid;
        break;
      end
      if (lat < 0 && dout_valid) begin
        lat = i;
        val = 32'(dout);
      end
    end
    check("latency", lat, 18);
    check("valid_width", 32'(pw), 0);
  endtask

  initial begin
    int v;
    int pulses;
    clear_hist();

    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", 32'(dout), 0);
    check("rst_valid", 32'(dout_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ovr", 32'(ovr), 0);
    check("rst_sat", 32'(sat), 0);
    rst = 1'b1;

    sample(0, v);
    check("first_zero", v, 0);

    sample(2047, v);
    check("impulse_0", v, IMP[0]);
    for (int i = 1; i < 17; i++) begin
      sample(0, v);
      check($sformatf("impulse_%0d", i), v, (i < 16) ? IMP[i] : 0);
    end

    for (int i = 0; i < 20; i++) begin
      sample(1000, v);
      if (i >= 15) check($sformatf("dc_%0d", i), v, 1000);
    end
    check("no_ovr_nominal", 32'(ovr), 0);

    @(posedge clk);
    #1;
    s_clk = 1'b1;
    din   = 12'sd500;
    push(500);
    @(posedge clk);
    #1;
    s_clk = 1'b0;
    din   = -12'sd700;
    repeat (4) @(posedge clk);
    #1;
    s_clk = 1'b1;
    check("ovr_busy_at_edge", 32'(busy), 1);
    @(posedge clk);
    #1;
    s_clk  = 1'b0;
    pulses = 0;
    v      = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dout_valid) begin
        pulses++;
        v = 32'(dout);
      end
    end
    check("ovr_flag", 32'(ovr), 1);
    check("ovr_pulses", pulses, 1);
    check("ovr_value", v, model());
    sample(0, v);
    check("ovr_dropped", v, model());
    check("ovr_sticky", 32'(ovr), 1);

    @(posedge clk);
    #1;
    s_clk = 1'b1;
    din   = 12'sd1234;
    @(posedge clk);
    #1;
    s_clk = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("mid_busy", 32'(busy), 1);
    rst = 1'b0;
    #1;
    check("mid_rst_dout", 32'(dout), 0);
    check("mid_rst_valid", 32'(dout_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_ovr", 32'(ovr), 0);
    check("mid_rst_sat", 32'(sat), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    clear_hist();
    sample(0, v);
    check("post_rst_zero", v, 0);

    for (int i = 0; i < 16; i++) begin
      sample(-2047, v);
      check($sformatf("neg_%0d", i), v, model());
    end
    check("neg_settled", v, -2047);
    for (int i = 0; i < 13; i++) begin
      sample(2047, v);
      check($sformatf("pos_%0d", i), v, model());
    end
    check("overshoot", v, OVERSHOOT);
    check("sat_flag", 32'(sat), SAT_END);

    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    clear_hist();
    for (int n = 0; n < 40; n++) begin
      sample(n * 100 - 2000, v);
      check($sformatf("ramp_%0d", n), v, model());
    end
    check("ramp_no_ovr", 32'(ovr), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
